mem_stage_lsu: RTL

- Parametrised load/store unit for the MEM pipeline stage; the sequential successor to the purely combinational memory stage.
- Owns the data-memory handshake: latches one memory op, holds the request stable until `dmem_resp_i`, and stalls the pipeline meanwhile.
- Generates byte enables and lane-aligned store data, then extracts and sign/zero-extends load data.
- Supports DW=32 or 64 data buses, detects misaligned accesses, and has an optional response watchdog.

---
 rtl/mem_stage_lsu.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: owns the data-memory handshake, lane-aligns stores,
// extracts and extends loads, flags misaligned ops and optionally aborts on a silent memory.
module mem_stage_lsu #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic            req_read_i,
    input  logic            req_write_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [31:0]     req_wdata_i,
    output logic            dmem_read_o,
    output logic            dmem_write_o,
    output logic [AW-1:0]   dmem_addr_o,
    output logic [DW-1:0]   dmem_wdata_o,
    output logic [DW/8-1:0] dmem_byte_en_o,
    input  logic [DW-1:0]   dmem_rdata_i,
    input  logic            dmem_resp_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [31:0]     load_data_o,
    output logic            misalign_o,
    output logic            timeout_o
);

    localparam int BEW = DW / 8;
    localparam int OW  = $clog2(BEW);
    localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state_q, state_d;
    logic            rd_q, rd_d, wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [BEW-1:0]  be_q, be_d;
    logic [2:0]      f3_q, f3_d;
    logic [OW-1:0]   off_q, off_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     load_q, load_d;

    logic [OW-1:0]   off;
    logic [3:0]      base_be;
    logic            mis;
    logic            mem_op;
    logic            start;
    logic            abort;
    logic [AW-1:0]   addr_al;
    logic [DW-1:0]   rshift;
    logic [31:0]     load_ext;

    assign off = req_addr_i[OW-1:0];

    always_comb begin
        base_be = 4'hF;
        mis     = |req_addr_i[1:0];
        unique case (req_funct3_i[1:0])
            2'b00: begin base_be = 4'h1; mis = 1'b0;          end
            2'b01: begin base_be = 4'h3; mis = req_addr_i[0]; end
            default: ;
        endcase
    end

    always_comb begin
        addr_al         = req_addr_i;
        addr_al[OW-1:0] = '0;
    end

    assign mem_op = req_valid_i & (req_read_i | req_write_i);
    assign start  = mem_op & ~mis & (state_q == S_IDLE);
    // A response in the last watchdog cycle takes priority over the abort.
    assign abort  = (TIMEOUT != 0) && (state_q == S_BUSY) && !dmem_resp_i && (cnt_q == TO_LAST);

    assign misalign_o = mem_op & mis & (state_q == S_IDLE);
    assign stall_o    = start | (state_q == S_BUSY);
    assign done_o     = (state_q == S_DONE);
    assign timeout_o  = abort;

    assign rshift = dmem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        load_ext = rshift[31:0];
        unique case (f3_q)
            3'b000:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  load_ext = {24'h0, rshift[7:0]};
            3'b101:  load_ext = {16'h0, rshift[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        off_d   = off_q;
        cnt_d   = '0;
        load_d  = load_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_d    = req_read_i;
                    wr_d    = req_write_i;
                    addr_d  = addr_al;
                    wdata_d = DW'(req_wdata_i) << {off, 3'b000};
                    be_d    = BEW'(base_be) << off;
                    f3_d    = req_funct3_i;
                    off_d   = off;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_resp_i || abort) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    load_d  = (dmem_resp_i && rd_q) ? load_ext : 32'h0;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
        end
    end

    assign dmem_read_o    = rd_q;
    assign dmem_write_o   = wr_q;
    assign dmem_addr_o    = addr_q;
    assign dmem_wdata_o   = wdata_q;
    assign dmem_byte_en_o = be_q;
    assign load_data_o    = load_q;

endmodule
